req_onehot_arbiter: RTL and testbench

//   Upstream stage of the 8-to-3 encoder path. Captures rising edges on 8 request

---
 rtl/arb_pkg.sv | 12 +
 rtl/rr_pick.sv | 39 +++
 rtl/req_onehot_arbiter.sv | 138 +++++++++++++
 tb/tb_req_onehot_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants and state type for the request arbiter ahead of the 8-to-3 encoder.
package arb_pkg;

  localparam int unsigned ARB_N = 8;
  localparam int unsigned PTR_W = $clog2(ARB_N);

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational winner selection: round-robin from ptr, or fixed highest-index priority.
module rr_pick #(
  parameter int unsigned N     = arb_pkg::ARB_N,
  parameter int unsigned PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     pending,
  input  logic [PTR_W-1:0] ptr,
  input  logic             rr,
  output logic             any,
  output logic [PTR_W-1:0] idx
);

  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [PTR_W-1:0] rot_pos;
  logic             found;
  logic [PTR_W-1:0] hi_pos;

  // Rotate so ptr lands at bit 0, take the lowest set bit, then un-rotate by adding ptr back.
  always_comb begin
    dbl     = {pending, pending};
    rot     = dbl[ptr +: N];
    rot_pos = '0;
    found   = 1'b0;
    hi_pos  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (rot[i] && !found) begin
        rot_pos = PTR_W'(i);
        found   = 1'b1;
      end
      if (pending[i]) begin
        hi_pos = PTR_W'(i);
      end
    end
    any = |pending;
    idx = rr ? (rot_pos + ptr) : hi_pos;
  end

endmodule

// File: rtl/req_onehot_arbiter.sv
// Captures rising edges on asynchronous request lines as sticky pending bits and
// presents one granted line as a one-hot vector, held until acknowledged.
module req_onehot_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N           = ARB_N,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          RR          = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_in,
  input  logic         clr,
  output logic [N-1:0] grant,
  output logic         grant_valid,
  input  logic         grant_ack,
  output logic [N-1:0] pending
);

  localparam int unsigned PW = $clog2(N);

  logic [N-1:0] sync_q [SYNC_STAGES];
  logic [N-1:0] sync_d [SYNC_STAGES];
  logic [N-1:0] prev_q;
  logic [N-1:0] prev_d;
  logic [N-1:0] edge_det;

  arb_state_e   state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] grant_q, grant_d;
  logic         valid_q, valid_d;
  logic [PW-1:0] winner_q, winner_d;
  logic [PW-1:0] ptr_q, ptr_d;

  logic          pick_any;
  logic [PW-1:0] pick_idx;

  // Synchronizer chain feed and previous-value tap used for rising-edge detection.
  always_comb begin
    sync_d[0] = req_in;
    for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
    prev_d   = sync_q[SYNC_STAGES-1];
    edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  // Capture registers: synchronizer stages and the previous synchronized value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      prev_q <= '0;
    end else begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      prev_q <= prev_d;
    end
  end

  rr_pick #(
    .N     (N),
    .PTR_W (PW)
  ) u_pick (
    .pending (pending_q),
    .ptr     (ptr_q),
    .rr      (RR),
    .any     (pick_any),
    .idx     (pick_idx)
  );

  // Next-state logic; a new edge on the winner in the ack cycle re-sets its pending bit,
  // and clr overrides everything except ptr.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | edge_det;
    grant_d   = grant_q;
    valid_d   = valid_q;
    winner_d  = winner_q;
    ptr_d     = ptr_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          winner_d = pick_idx;
          grant_d  = N'(1) << pick_idx;
          valid_d  = 1'b1;
          state_d  = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (grant_ack) begin
          pending_d = (pending_q & ~grant_q) | edge_det;
          grant_d   = '0;
          valid_d   = 1'b0;
          state_d   = ARB_IDLE;
          if (RR) begin
            ptr_d = winner_q + PW'(1);
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
    if (clr) begin
      pending_d = '0;
      grant_d   = '0;
      valid_d   = 1'b0;
      state_d   = ARB_IDLE;
    end
  end

  // Arbitration FSM with registered grant outputs and sticky pending bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      pending_q <= '0;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      winner_q  <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      winner_q  <= winner_d;
      ptr_q     <= ptr_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_req_onehot_arbiter.sv
// Scoreboard bench: a round-robin and a fixed-priority arbiter share stimulus; a
// request-level reference model predicts pending bits and grant order.
module tb_req_onehot_arbiter;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req_in = '0;
  logic       clr = 1'b0;
  logic       grant_ack = 1'b0;

  logic [7:0] grant_rr, grant_fp, pend_rr, pend_fp;
  logic       valid_rr, valid_fp;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  req_onehot_arbiter #(.N(8), .SYNC_STAGES(2), .RR(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .clr(clr),
    .grant(grant_rr), .grant_valid(valid_rr), .grant_ack(grant_ack), .pending(pend_rr)
  );

  req_onehot_arbiter #(.N(8), .SYNC_STAGES(2), .RR(1'b0)) u_fp (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .clr(clr),
    .grant(grant_fp), .grant_valid(valid_fp), .grant_ack(grant_ack), .pending(pend_fp)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_sync [SYNC];
  logic [7:0] m_prev = '0;
  logic [7:0] m_pend [2];
  bit         m_busy [2];
  int         m_win  [2];
  int         m_ptr  [2];
  logic [7:0] q_rr [$];
  logic [7:0] q_fp [$];

  function automatic int pick(input logic [7:0] p, input int ptr, input bit rr);
    if (rr) begin
      for (int k = 0; k < 8; k++)
        if (p[(ptr + k) % 8]) return (ptr + k) % 8;
    end else begin
      for (int i = 7; i >= 0; i--)
        if (p[i]) return i;
    end
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC; s++) m_sync[s] = '0;
      m_prev = '0;
      for (int k = 0; k < 2; k++) begin
        m_pend[k] = '0; m_busy[k] = 0; m_win[k] = 0; m_ptr[k] = 0;
      end
    end else begin
      logic [7:0] edg;
      logic [7:0] one;
      edg = m_sync[SYNC-1] & ~m_prev;
      for (int k = 0; k < 2; k++) begin
        if (clr) begin
          m_pend[k] = '0;
          m_busy[k] = 0;
        end else if (m_busy[k] && grant_ack) begin
          one = 8'h01 << m_win[k];
          m_pend[k] = (m_pend[k] & ~one) | edg;
          m_busy[k] = 0;
          if (k == 0) m_ptr[k] = (m_win[k] + 1) % 8;
        end else if (!m_busy[k] && m_pend[k] != 0) begin
          m_win[k] = pick(m_pend[k], m_ptr[k], k == 0);
          m_busy[k] = 1;
          one = 8'h01 << m_win[k];
          if (k == 0) q_rr.push_back(one); else q_fp.push_back(one);
          m_pend[k] = m_pend[k] | edg;
        end else begin
          m_pend[k] = m_pend[k] | edg;
        end
      end
      m_prev = m_sync[SYNC-1];
      for (int s = SYNC - 1; s > 0; s--) m_sync[s] = m_sync[s-1];
      m_sync[0] = req_in;
    end
  end

  // ---------------- monitor ----------------
  logic       pv [2] = '{0, 0};
  logic [7:0] pg [2] = '{8'h00, 8'h00};

  always @(negedge clk) begin
    if (!rst_n) begin
      pv[0] = 0; pv[1] = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic [7:0] g, p, e;
        logic       v;
        g = (k == 0) ? grant_rr : grant_fp;
        p = (k == 0) ? pend_rr : pend_fp;
        v = (k == 0) ? valid_rr : valid_fp;
        chk($sformatf("pending_model[%0d]", k), p, m_pend[k]);
        chk($sformatf("valid_model[%0d]", k), {7'd0, v}, {7'd0, m_busy[k]});
        chk($sformatf("onehot0[%0d]", k), {7'd0, $onehot0(g)}, 8'h01);
        chk($sformatf("valid_vs_grant[%0d]", k), {7'd0, g != 8'h00}, {7'd0, v});
        if (v && !pv[k]) begin
          if (k == 0 && q_rr.size() == 0 || k == 1 && q_fp.size() == 0) begin
            chk($sformatf("grant_unexpected[%0d]", k), g, 8'h00);
          end else begin
            e = (k == 0) ? q_rr.pop_front() : q_fp.pop_front();
            chk($sformatf("grant_order[%0d]", k), g, e);
          end
        end else if (v && pv[k]) begin
          chk($sformatf("grant_stable[%0d]", k), g, pg[k]);
        end
        pv[k] = v;
        pg[k] = g;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_in = '0; clr = 1'b0; grant_ack = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic ack_pulse();
    grant_ack = 1'b1;
    tick(1);
    grant_ack = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("reset_grant", grant_rr, 8'h00);
    chk("reset_valid", {7'd0, valid_rr}, 8'h00);
    chk("reset_pending", pend_rr, 8'h00);

    // single request: capture latency, grant, ack
    req_in = 8'h10;
    tick(2);
    chk("t1_pend_before", pend_rr, 8'h00);
    tick(1);
    chk("t1_pend_set", pend_rr, 8'h10);
    chk("t1_no_grant_yet", {7'd0, valid_rr}, 8'h00);
    tick(1);
    chk("t1_grant", grant_rr, 8'h10);
    chk("t1_valid", {7'd0, valid_rr}, 8'h01);
    req_in = '0;
    ack_pulse();
    chk("t1_ack_valid", {7'd0, valid_rr}, 8'h00);
    chk("t1_ack_pend", pend_rr, 8'h00);

    // simultaneous requests on lines 0 and 7 from ptr=0
    do_reset();
    req_in = 8'h81;
    tick(3);
    chk("t2_pend", pend_rr, 8'h81);
    tick(1);
    chk("t2_rr_first", grant_rr, 8'h01);
    chk("t2_fp_first", grant_fp, 8'h80);
    ack_pulse();
    chk("t2_gap_valid", {7'd0, valid_rr}, 8'h00);
    chk("t2_rr_pend_left", pend_rr, 8'h80);
    tick(1);
    chk("t2_rr_second", grant_rr, 8'h80);
    chk("t2_fp_second", grant_fp, 8'h01);
    ack_pulse();
    req_in = '0;
    tick(3);
    req_in = 8'h81;
    tick(4);
    chk("t2_rr_ptr_back_to_0", grant_rr, 8'h01);
    ack_pulse();
    tick(1);
    ack_pulse();
    req_in = '0;
    tick(3);

    // move ptr to 7, then pending 8'h41 wraps to line 0 first
    req_in = 8'h40;
    tick(4);
    chk("t3_setup_grant", grant_rr, 8'h40);
    req_in = '0;
    ack_pulse();
    tick(2);
    req_in = 8'h41;
    tick(4);
    chk("t3_rr_wrap_first", grant_rr, 8'h01);
    chk("t3_fp_first", grant_fp, 8'h40);
    ack_pulse();
    tick(1);
    chk("t3_rr_second", grant_rr, 8'h40);
    chk("t3_fp_second", grant_fp, 8'h01);
    ack_pulse();
    req_in = '0;
    tick(3);

    // new edge on the granted line in the ack cycle keeps it pending
    req_in = 8'h04;
    tick(4);
    chk("t4_grant", grant_rr, 8'h04);
    req_in = '0;
    tick(3);
    req_in = 8'h04;
    tick(2);
    ack_pulse();
    chk("t4_gap_valid", {7'd0, valid_rr}, 8'h00);
    chk("t4_pend_kept", pend_rr, 8'h04);
    tick(1);
    chk("t4_regrant", grant_rr, 8'h04);
    ack_pulse();
    req_in = '0;
    tick(3);

    // clr with ack and new edges
    req_in = 8'h10;
    tick(4);
    chk("t5_grant", grant_rr, 8'h10);
    req_in = 8'h1F;
    tick(2);
    grant_ack = 1'b1; clr = 1'b1;
    tick(1);
    grant_ack = 1'b0; clr = 1'b0;
    chk("t5_pend_rr", pend_rr, 8'h00);
    chk("t5_pend_fp", pend_fp, 8'h00);
    chk("t5_grant", grant_rr, 8'h00);
    chk("t5_valid", {7'd0, valid_rr}, 8'h00);
    tick(2);
    chk("t5_stays_idle", pend_rr, 8'h00);
    req_in = '0;
    tick(3);

    // asynchronous reset mid-grant with request held high
    req_in = 8'h20;
    tick(4);
    chk("t6_grant", grant_rr, 8'h20);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_grant", grant_rr, 8'h00);
    chk("t6_async_valid", {7'd0, valid_rr}, 8'h00);
    chk("t6_async_pend", pend_rr, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick(3);
    chk("t6_pend_after_release", pend_rr, 8'h20);
    tick(1);
    chk("t6_regrant", grant_rr, 8'h20);
    ack_pulse();
    req_in = '0;
    tick(3);

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req_in = req_in ^ 8'($urandom);
      grant_ack = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 39) == 0);
      tick(1);
    end

    // drain
    req_in = '0; clr = 1'b0; grant_ack = 1'b1;
    tick(30);
    grant_ack = 1'b0;
    tick(2);
    chk("drain_rr_queue", 8'(q_rr.size()), 8'h00);
    chk("drain_fp_queue", 8'(q_fp.size()), 8'h00);
    chk("drain_pending", pend_rr | pend_fp, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
